captura_pin: RTL and testbench



---
 rtl/captura_pin_pkg.sv | 23 ++
 rtl/captura_pin_contador_timeout.sv | 30 +++
 rtl/captura_pin.sv | 118 +++++++++++
 tb/tb_captura_pin.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/captura_pin_pkg.sv
// Constants and types shared by the PIN capture front-end and the ATM controller.
package captura_pin_pkg;

  // Keypad code for backspace; shared with the controller.
  localparam logic [3:0] VACIO      = 4'hF;
  // Largest legal decimal digit code.
  localparam logic [3:0] DIGITO_MAX = 4'd9;
  // Width of the packed PIN word (four BCD digits).
  localparam int         PIN_W      = 16;

  // One-hot capture states.
  typedef enum logic [2:0] {
    INACTIVO = 3'b001,
    CAPTURA  = 3'b010,
    LISTO    = 3'b100
  } estado_t;

  // True when a keypad code is a decimal digit 0-9.
  function automatic logic es_digito(input logic [3:0] codigo);
    return codigo <= DIGITO_MAX;
  endfunction

endpackage

// File: rtl/captura_pin_contador_timeout.sv
// Saturating up-counter with clear/enable and a terminal-count flag.
// Reused for idle timeouts here and for session timeouts in the controller.
module contador_timeout #(
  parameter int W        = 10,
  parameter int TERMINAL = 999
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [W-1:0] cuenta;

  assign terminal = (cuenta == W'(TERMINAL));

  // Count up while enabled; clear wins; hold at the terminal value so it never wraps.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (reset) begin
      cuenta <= '0;
    end else if (clear) begin
      cuenta <= '0;
    end else if (enable && !terminal) begin
      cuenta <= cuenta + W'(1);
    end
  end

endmodule

// File: rtl/captura_pin.sv
// Keypad PIN capture: collects BCD digit strobes with backspace, packs four
// digits into a 16-bit word, hands it to the controller with valid/ack, and
// discards a partial entry after an inter-digit idle timeout.
module captura_pin
  import captura_pin_pkg::*;
#(
  parameter int NUM_DIGITOS    = 4,
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int TIMEOUT_W      = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tarjeta_recibida,
  input  logic             digito_stb,
  input  logic [3:0]       digito,
  input  logic             pin_ack,
  output logic [PIN_W-1:0] pin_ingresado,
  output logic             pin_valido,
  output logic [2:0]       digitos_ingresados,
  output logic             digito_invalido,
  output logic             tiempo_agotado
);

  estado_t estado;
  logic    timer_clear;
  logic    timer_terminal;

  // Timer runs only while a partial entry sits idle in CAPTURA; everything else holds it at 0.
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    timer_clear = 1'b1;
    if (tarjeta_recibida && estado == CAPTURA && !digito_stb &&
        digitos_ingresados != 3'd0 && !timer_terminal) begin
      timer_clear = 1'b0;
    end
  end

  contador_timeout #(
    .W        (TIMEOUT_W),
    .TERMINAL (TIMEOUT_CICLOS - 1)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (1'b1),
    .terminal (timer_terminal)
  );

  // Capture FSM with registered PIN, count, handshake and pulse outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado             <= INACTIVO;
      pin_ingresado      <= '0;
      pin_valido         <= 1'b0;
      digitos_ingresados <= 3'd0;
      digito_invalido    <= 1'b0;
      tiempo_agotado     <= 1'b0;
    end else begin
      digito_invalido <= 1'b0;
      tiempo_agotado  <= 1'b0;
      if (!tarjeta_recibida) begin
        // Card removal overrides everything, including a pending ack.
        estado             <= INACTIVO;
        pin_ingresado      <= '0;
        pin_valido         <= 1'b0;
        digitos_ingresados <= 3'd0;
      end else begin
        case (estado)
          INACTIVO: begin
            estado             <= CAPTURA;
            pin_ingresado      <= '0;
            pin_valido         <= 1'b0;
            digitos_ingresados <= 3'd0;
          end
          CAPTURA: begin
            if (digito_stb) begin
              if (es_digito(digito)) begin
                pin_ingresado      <= {pin_ingresado[11:0], digito};
                digitos_ingresados <= digitos_ingresados + 3'd1;
                if (digitos_ingresados == 3'(NUM_DIGITOS - 1)) begin
                  estado     <= LISTO;
                  pin_valido <= 1'b1;
                end
              end else if (digito == VACIO) begin
                if (digitos_ingresados != 3'd0) begin
                  pin_ingresado      <= {4'h0, pin_ingresado[15:4]};
                  digitos_ingresados <= digitos_ingresados - 3'd1;
                end
              end else begin
                digito_invalido <= 1'b1;
              end
            end else if (digitos_ingresados != 3'd0 && timer_terminal) begin
              // Idle too long: drop the partial entry but stay ready for a new one.
              tiempo_agotado     <= 1'b1;
              pin_ingresado      <= '0;
              digitos_ingresados <= 3'd0;
            end
          end
          LISTO: begin
            if (pin_ack) begin
              estado             <= CAPTURA;
              pin_ingresado      <= '0;
              pin_valido         <= 1'b0;
              digitos_ingresados <= 3'd0;
            end
          end
          default: begin
            estado             <= INACTIVO;
            pin_ingresado      <= '0;
            pin_valido         <= 1'b0;
            digitos_ingresados <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_captura_pin.sv
// Directed bench for captura_pin with a short idle timeout.
module tb_captura_pin;

  localparam int T = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tarjeta_recibida = 1'b0;
  logic        digito_stb = 1'b0;
  logic [3:0]  digito = 4'h0;
  logic        pin_ack = 1'b0;
  logic [15:0] pin_ingresado;
  logic        pin_valido;
  logic [2:0]  digitos_ingresados;
  logic        digito_invalido;
  logic        tiempo_agotado;

  int vectors = 0;
  int miscompares = 0;

  captura_pin #(
    .NUM_DIGITOS    (4),
    .TIMEOUT_CICLOS (T),
    .TIMEOUT_W      (4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .tarjeta_recibida   (tarjeta_recibida),
    .digito_stb         (digito_stb),
    .digito             (digito),
    .pin_ack            (pin_ack),
    .pin_ingresado      (pin_ingresado),
    .pin_valido         (pin_valido),
    .digitos_ingresados (digitos_ingresados),
    .digito_invalido    (digito_invalido),
    .tiempo_agotado     (tiempo_agotado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Check the full output set in one call.
  task automatic check_all(input string tag, input logic [15:0] pin, input logic valido,
                           input logic [2:0] cnt, input logic inval, input logic tout);
    check({tag, ".pin"}, pin_ingresado, pin);
    check({tag, ".valido"}, {15'd0, pin_valido}, {15'd0, valido});
    check({tag, ".cnt"}, {13'd0, digitos_ingresados}, {13'd0, cnt});
    check({tag, ".inval"}, {15'd0, digito_invalido}, {15'd0, inval});
    check({tag, ".tout"}, {15'd0, tiempo_agotado}, {15'd0, tout});
  endtask

  // One-cycle strobe; returns at the negedge after the sampling edge.
  task automatic strobe(input logic [3:0] d);
    digito_stb = 1'b1;
    digito     = d;
    @(negedge clock);
    digito_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic ack;
    pin_ack = 1'b1;
    @(negedge clock);
    pin_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(2);
    check_all("reset", 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Basic entry 1,2,3,4 with gaps, then ack
    tarjeta_recibida = 1'b1;
    idle(1);
    strobe(4'd1); idle(1);
    strobe(4'd2); idle(1);
    strobe(4'd3);
    check_all("e1_three", 16'h0123, 1'b0, 3'd3, 1'b0, 1'b0);
    idle(1);
    strobe(4'd4);
    check_all("e1_four", 16'h1234, 1'b1, 3'd4, 1'b0, 1'b0);
    ack();
    check_all("e1_ack", 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);

    // Backspace mid-entry: 5,6,F,7,8,9 -> 5789
    strobe(4'd5);
    strobe(4'd6);
    strobe(4'hF);
    check_all("bs_mid", 16'h0005, 1'b0, 3'd1, 1'b0, 1'b0);
    strobe(4'd7);
    strobe(4'd8);
    strobe(4'd9);
    check_all("bs_final", 16'h5789, 1'b1, 3'd4, 1'b0, 1'b0);
    ack();
    // Backspace with nothing held
    strobe(4'hF);
    check_all("bs_empty", 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);

    // Timeout: pulse 8 cycles after the strobe
    strobe(4'd3);
    idle(T - 1);
    check_all("to_before", 16'h0003, 1'b0, 3'd1, 1'b0, 1'b0);
    idle(1);
    check_all("to_pulse", 16'h0000, 1'b0, 3'd0, 1'b0, 1'b1);
    idle(1);
    check_all("to_after", 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);

    // Strobe on the terminal cycle wins
    strobe(4'd3);
    idle(T - 1);
    strobe(4'd4);
    check_all("to_race", 16'h0034, 1'b0, 3'd2, 1'b0, 1'b0);
    idle(1);
    check_all("to_race_next", 16'h0034, 1'b0, 3'd2, 1'b0, 1'b0);

    // Illegal code
    strobe(4'hB);
    check_all("inval", 16'h0034, 1'b0, 3'd2, 1'b1, 1'b0);
    idle(1);
    check_all("inval_end", 16'h0034, 1'b0, 3'd2, 1'b0, 1'b0);

    // Strobes ignored in LISTO
    strobe(4'd5);
    strobe(4'd6);
    check_all("listo", 16'h3456, 1'b1, 3'd4, 1'b0, 1'b0);
    strobe(4'd7);
    strobe(4'hF);
    strobe(4'hC);
    check_all("listo_ign", 16'h3456, 1'b1, 3'd4, 1'b0, 1'b0);
    ack();

    // Card removed coincident with a strobe after 2 digits
    strobe(4'd1);
    strobe(4'd2);
    check_all("card_two", 16'h0012, 1'b0, 3'd2, 1'b0, 1'b0);
    tarjeta_recibida = 1'b0;
    strobe(4'd3);
    check_all("card_out", 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);
    strobe(4'd4);
    strobe(4'hA);
    idle(2);
    check_all("card_ign", 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);

    // Re-insert, 3 digits, async reset between edges
    tarjeta_recibida = 1'b1;
    idle(1);
    strobe(4'd9);
    strobe(4'd0);
    strobe(4'd0);
    check_all("pre_rst", 16'h0900, 1'b0, 3'd3, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check_all("async_rst", 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    idle(1);
    strobe(4'd9);
    strobe(4'd0);
    strobe(4'd0);
    strobe(4'd1);
    check_all("post_rst", 16'h9001, 1'b1, 3'd4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
